audio_mix_sat: RTL and testbench

- Parametrised N-channel audio mixer that replaces the fixed adder and 3-bit clip table in the emu top level.
- On each sample strobe it:
  - captures all channel samples;
  - converts unsigned sources to signed by flipping the MSB;
  - applies a per-channel gain;
  - accumulates serially, one channel per clock;
  - saturates the sum to OUT_W signed.
- Sits between the core's audio sources (PSG, OPLL, PCM) and AUDIO_L/AUDIO_R, clocked on clk_sys.

---
 rtl/audio_mix_sat.sv | 191 +++++++++++++++++++
 tb/tb_audio_mix_sat.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_sat.sv
// rtl/audio_mix_sat.sv - serial N-channel audio mixer with per-channel gain and output saturation
//
// Purpose:
//   On each sample_ce strobe the mixer snapshots every channel, then walks the
//   channels one per clock: offset-binary sources are re-centred to signed,
//   scaled by their gain and summed. The sum is rescaled by unity gain,
//   aligned to OUT_W and clamped to the signed OUT_W range.
//
// Ports:
//   clk_sys      system clock
//   reset        synchronous, active-high reset
//   sample_ce    one-cycle strobe starting a new mix
//   ch_data      packed channel samples, channel k at [k*IN_W +: IN_W]
//   ch_unsigned  bit k set: channel k is offset-binary
//   ch_gain      packed unsigned gains, unity = 2^(GAIN_W-1)
//   master_mute  forces the output sample (and clip) to 0
//   audio_out    signed mixed sample, held between updates
//   audio_valid  one-cycle pulse when audio_out updates
//   busy         high while a mix is in progress
//   clip         last sample saturated, valid with audio_out
//   overrun      one-cycle pulse when a strobe arrives while busy
//   clip_led     clip activity indicator (only with AUDIO_MIX_SAT_CLIP_HOLD_EN)
//
// Optional feature macro: AUDIO_MIX_SAT_CLIP_HOLD_EN adds parameter CLIP_HOLD
// and output clip_led, held high for CLIP_HOLD clocks after any clipped sample.

module audio_mix_sat #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int GAIN_W   = 4
`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
  , parameter int CLIP_HOLD = 1000000
`endif
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       sample_ce,
  input  logic [CHANNELS*IN_W-1:0]   ch_data,
  input  logic [CHANNELS-1:0]        ch_unsigned,
  input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
  input  logic                       master_mute,
  output logic [OUT_W-1:0]           audio_out,
  output logic                       audio_valid,
  output logic                       busy,
  output logic                       clip,
  output logic                       overrun
`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
  , output logic                     clip_led
`endif
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int P_W   = IN_W + GAIN_W + 1;
  // One guard bit per doubling of channel count keeps the running sum exact.
  localparam int ACC_W = IN_W + GAIN_W + $clog2(CHANNELS) + 1;
  localparam int SHL   = OUT_W - IN_W;
  localparam int V_W   = ACC_W + SHL;

  localparam logic signed [V_W-1:0] V_MAX = V_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [V_W-1:0] V_MIN = ~V_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;
  state_t state, state_nxt;

  logic [CHANNELS*IN_W-1:0]   sh_data;
  logic [CHANNELS-1:0]        sh_unsigned;
  logic [CHANNELS*GAIN_W-1:0] sh_gain;
  logic                       sh_mute;
  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc;

  logic [IN_W-1:0]            cur_d;
  logic                       cur_u;
  logic [GAIN_W-1:0]          cur_g;
  logic signed [IN_W-1:0]     cur_s;
  logic signed [P_W-1:0]      s_ext, g_ext, prod;
  logic signed [ACC_W-1:0]    acc_sh;
  logic signed [V_W-1:0]      v;
  logic                       sat_hi, sat_lo;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_ce) state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_W'(CHANNELS-1)) state_nxt = SAT;
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign overrun = sample_ce & busy;

  always_comb begin
    cur_d = '0;
    cur_u = 1'b0;
    cur_g = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_d = sh_data[k*IN_W +: IN_W];
        cur_u = sh_unsigned[k];
        cur_g = sh_gain[k*GAIN_W +: GAIN_W];
      end
    end
  end

  // Flipping the MSB turns offset-binary into two's complement.
  assign cur_s  = cur_d ^ {cur_u, {(IN_W-1){1'b0}}};
  assign s_ext  = P_W'(cur_s);
  assign g_ext  = P_W'($signed({1'b0, cur_g}));
  assign prod   = s_ext * g_ext;

  // Divide out unity gain, then MSB-align to the output width.
  assign acc_sh = acc >>> (GAIN_W-1);
  assign v      = V_W'(acc_sh) <<< SHL;
  assign sat_hi = (v > V_MAX);
  assign sat_lo = (v < V_MIN);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sh_data     <= '0;
      sh_unsigned <= '0;
      sh_gain     <= '0;
      sh_mute     <= 1'b0;
      idx         <= '0;
      acc         <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      clip        <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_ce) begin
            sh_data     <= ch_data;
            sh_unsigned <= ch_unsigned;
            sh_gain     <= ch_gain;
            sh_mute     <= master_mute;
            idx         <= '0;
            acc         <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + IDX_W'(1);
        end
        SAT: begin
          audio_valid <= 1'b1;
          if (sh_mute) begin
            audio_out <= '0;
            clip      <= 1'b0;
          end else if (sat_hi) begin
            audio_out <= V_MAX[OUT_W-1:0];
            clip      <= 1'b1;
          end else if (sat_lo) begin
            audio_out <= V_MIN[OUT_W-1:0];
            clip      <= 1'b1;
          end else begin
            audio_out <= v[OUT_W-1:0];
            clip      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
  localparam int CNT_W = $clog2(CLIP_HOLD + 1);
  logic [CNT_W-1:0] clip_cnt;

  // A fresh clipped sample restarts the hold period.
  always_ff @(posedge clk_sys) begin
    if (reset)
      clip_cnt <= '0;
    else if (state == SAT && !sh_mute && (sat_hi || sat_lo))
      clip_cnt <= CNT_W'(CLIP_HOLD);
    else if (clip_cnt != '0)
      clip_cnt <= clip_cnt - CNT_W'(1);
  end

  assign clip_led = (clip_cnt != '0);
`endif

endmodule

// File: tb/tb_audio_mix_sat.sv
// tb/tb_audio_mix_sat.sv - randomized self-checking bench for audio_mix_sat

module tb_audio_mix_sat;

  localparam int CH = 4;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int GW = 4;

  logic           clk_sys = 1'b0;
  logic           reset;
  logic           sample_ce;
  logic [CH*IW-1:0] ch_data;
  logic [CH-1:0]  ch_unsigned;
  logic [CH*GW-1:0] ch_gain;
  logic           master_mute;
  logic [OW-1:0]  audio_out;
  logic           audio_valid;
  logic           busy;
  logic           clip;
  logic           overrun;
`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
  logic           clip_led;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
  audio_mix_sat #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW), .CLIP_HOLD(20)) dut (
`else
  audio_mix_sat #(.CHANNELS(CH), .IN_W(IW), .OUT_W(OW), .GAIN_W(GW)) dut (
`endif
    .clk_sys     (clk_sys),
    .reset       (reset),
    .sample_ce   (sample_ce),
    .ch_data     (ch_data),
    .ch_unsigned (ch_unsigned),
    .ch_gain     (ch_gain),
    .master_mute (master_mute),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .busy        (busy),
    .clip        (clip),
    .overrun     (overrun)
`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
    , .clip_led  (clip_led)
`endif
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mixing rules.
  function automatic void ref_mix(input logic [CH*IW-1:0] d, input logic [CH-1:0] u,
                                  input logic [CH*GW-1:0] g, input logic m,
                                  output longint o, output bit c);
    longint sum, s, v;
    sum = 0;
    for (int k = 0; k < CH; k++) begin
      s = longint'(d[k*IW +: IW]);
      if (u[k])             s = s - 32768;
      else if (s >= 32768)  s = s - 65536;
      sum += s * longint'(g[k*GW +: GW]);
    end
    v = sum >>> (GW-1);
    v = v * (longint'(1) << (OW-IW));
    if (v > 32767)       begin o = 32767;  c = 1'b1; end
    else if (v < -32768) begin o = -32768; c = 1'b1; end
    else                 begin o = v;      c = 1'b0; end
    if (m) begin o = 0; c = 1'b0; end
  endfunction

  function automatic longint out_s();
    return longint'($signed(audio_out));
  endfunction

  task automatic run_mix(input logic [CH*IW-1:0] d, input logic [CH-1:0] u,
                         input logic [CH*GW-1:0] g, input logic m, input string tag);
    longint exp_o;
    bit     exp_c;
    int     lat;
    ref_mix(d, u, g, m, exp_o, exp_c);
    @(negedge clk_sys);
    ch_data = d; ch_unsigned = u; ch_gain = g; master_mute = m;
    sample_ce = 1'b1;
    @(negedge clk_sys);
    sample_ce = 1'b0;
    // Scramble inputs: the mix must only use what was latched.
    ch_data = {$urandom, $urandom};
    ch_unsigned = 4'($urandom);
    ch_gain = 16'($urandom);
    master_mute = 1'($urandom);
    check_val({tag, ".busy"}, busy, 1);
    lat = 1;
    while (!audio_valid && lat < 20) begin
      @(negedge clk_sys);
      lat++;
    end
    check_val({tag, ".lat"}, lat, 6);
    check_val({tag, ".out"}, out_s(), exp_o);
    check_val({tag, ".clip"}, clip, exp_c);
    check_val({tag, ".busy_end"}, busy, 0);
  endtask

  initial begin
    int vcount, lat, n;
    reset = 1'b1; sample_ce = 1'b0; ch_data = '0; ch_unsigned = '0;
    ch_gain = '0; master_mute = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check_val("rst.out", audio_out, 0);
    check_val("rst.valid", audio_valid, 0);
    check_val("rst.busy", busy, 0);
    check_val("rst.clip", clip, 0);
    check_val("rst.overrun", overrun, 0);

    run_mix(64'h0000_0000_0000_1000, 4'b0000, 16'h0008, 1'b0, "t1");
    run_mix(64'h0000_0000_8000_0000, 4'b0010, 16'h00F0, 1'b0, "t2");
    run_mix(64'h7000_7000_7000_7000, 4'b0000, 16'h8888, 1'b0, "t3pos");
    run_mix(64'h9000_9000_9000_9000, 4'b0000, 16'h8888, 1'b0, "t3neg");
    run_mix(64'h7000_7000_7000_7000, 4'b0000, 16'h8888, 1'b1, "mute");
    run_mix(64'h8000_8000_8000_8000, 4'b1111, 16'hFFFF, 1'b0, "midall");
    run_mix(64'h0000_FFFF_8000_7FFF, 4'b0000, 16'hF0FF, 1'b0, "edge");

    for (int i = 0; i < 40; i++)
      run_mix({$urandom, $urandom}, 4'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0), "rand");

    // Overrun while busy, then an accepted strobe after the mix.
    @(negedge clk_sys);
    ch_data = 64'h0000_0000_0000_1000; ch_unsigned = '0; ch_gain = 16'h0008; master_mute = 1'b0;
    sample_ce = 1'b1;
    @(negedge clk_sys); sample_ce = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    ch_data = 64'h7000_7000_7000_7000; ch_gain = 16'h8888;
    sample_ce = 1'b1;
    #1 check_val("ovr.pulse", overrun, 1);
    vcount = 0;
    @(negedge clk_sys); sample_ce = 1'b0;
    #1 check_val("ovr.clear", overrun, 0);
    vcount += int'(audio_valid);
    @(negedge clk_sys); vcount += int'(audio_valid);
    @(negedge clk_sys); vcount += int'(audio_valid);
    check_val("ovr.valid6", audio_valid, 1);
    check_val("ovr.out", out_s(), 4096);
    check_val("ovr.vcount", vcount, 1);
    @(negedge clk_sys);
    check_val("ovr.valid7", audio_valid, 0);
    ch_data = 64'h7000_7000_7000_7000; ch_gain = 16'h8888;
    sample_ce = 1'b1;
    #1 check_val("ovr.accept", overrun, 0);
    @(negedge clk_sys); sample_ce = 1'b0;
    lat = 1;
    while (!audio_valid && lat < 20) begin
      @(negedge clk_sys);
      lat++;
    end
    check_val("ovr.lat2", lat, 6);
    check_val("ovr.out2", out_s(), 32767);
    check_val("ovr.clip2", clip, 1);

    // Reset mid-mix abandons it.
    @(negedge clk_sys);
    ch_data = 64'h0000_0000_0000_1000; ch_gain = 16'h0008;
    sample_ce = 1'b1;
    @(negedge clk_sys); sample_ce = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); reset = 1'b0;
    check_val("mid.out", audio_out, 0);
    check_val("mid.valid", audio_valid, 0);
    check_val("mid.busy", busy, 0);
    check_val("mid.clip", clip, 0);
    vcount = 0;
    repeat (12) begin
      @(negedge clk_sys);
      vcount += int'(audio_valid);
    end
    check_val("mid.novalid", vcount, 0);
    run_mix(64'h0000_0000_0000_1000, 4'b0000, 16'h0008, 1'b0, "post");

`ifdef AUDIO_MIX_SAT_CLIP_HOLD_EN
    run_mix(64'h7000_7000_7000_7000, 4'b0000, 16'h8888, 1'b0, "led");
    n = 0;
    while (clip_led && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check_val("led.hold", n, 20);
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
